// File: rtl/fifo_input_conditioner_if.sv
// Bundle between the board-input conditioner and its surroundings.
//   Raw side   : btn_wr, btn_rd (bouncy push-buttons), sw[dbit] (slide switches)
//   FIFO side  : write, read (debounced levels), din[dbit] (held data word),
//                wr_rel, rd_rel (one-cycle release pulses)
// slave  = the conditioner (consumes raw inputs, produces FIFO-side levels)
// master = board / testbench side
interface fifo_input_conditioner_if #(
    parameter int dbit = 3
);
    logic            btn_wr;
    logic            btn_rd;
    logic [dbit-1:0] sw;
    logic            write;
    logic            read;
    logic [dbit-1:0] din;
    logic            wr_rel;
    logic            rd_rel;

    modport master (
        output btn_wr, btn_rd, sw,
        input  write, read, din, wr_rel, rd_rel
    );

    modport slave (
        input  btn_wr, btn_rd, sw,
        output write, read, din, wr_rel, rd_rel
    );
endinterface

// File: rtl/fifo_input_conditioner.sv
// Conditions raw board buttons/switches into clean FIFO write/read/din.
//   clk  : single clock
//   rst  : synchronous, active-high reset
//   bus  : fifo_input_conditioner_if.slave
//          in : btn_wr, btn_rd, sw[dbit]
//          out: write, read, din[dbit], wr_rel, rd_rel
// Channel 0 is the write button, channel 1 the read button.
//
//   state     | meaning
//   ----------+--------------------------------------------------
//   ST_LOW    | committed low, waiting for a synchronised 1
//   ST_ARM_HI | candidate press, counting stable 1 samples
//   ST_HIGH   | committed high, waiting for a synchronised 0
//   ST_ARM_LO | candidate release, counting stable 0 samples
module fifo_input_conditioner #(
    parameter int dbit      = 3,
    parameter int DB_CYCLES = 1000000,
    parameter int CNT_W     = 20
) (
    input  logic                      clk,
    input  logic                      rst,
    fifo_input_conditioner_if.slave   bus
);

    localparam logic [1:0] ST_LOW    = 2'd0;
    localparam logic [1:0] ST_ARM_HI = 2'd1;
    localparam logic [1:0] ST_HIGH   = 2'd2;
    localparam logic [1:0] ST_ARM_LO = 2'd3;

    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [2:0]       GUARD_MAX = 3'd4;

    // two-flop synchronisers
    logic [1:0]      btn_meta_q, btn_meta_d;
    logic [1:0]      btn_s_q,    btn_s_d;
    logic [dbit-1:0] sw_meta_q,  sw_meta_d;
    logic [dbit-1:0] sw_s_q,     sw_s_d;

    // per-channel debounce state
    logic [1:0][1:0]       state_q, state_d;
    logic [1:0][CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]            lvl_q,   lvl_d;
    logic [1:0]            rel_q,   rel_d;

    // data hold
    logic [2:0]      guard_q, guard_d;
    logic [dbit-1:0] din_q,   din_d;

    always_comb begin
        btn_meta_d = {bus.btn_rd, bus.btn_wr};
        btn_s_d    = btn_meta_q;
        sw_meta_d  = bus.sw;
        sw_s_d     = sw_meta_q;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lvl_d   = '0;
        rel_d   = '0;
        for (int i = 0; i < 2; i++) begin
            case (state_q[i])
                ST_LOW: begin
                    if (btn_s_q[i]) begin
                        state_d[i] = ST_ARM_HI;
                        cnt_d[i]   = '0;
                    end
                end
                ST_ARM_HI: begin
                    if (!btn_s_q[i]) begin
                        state_d[i] = ST_LOW;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_TC) begin
                        state_d[i] = ST_HIGH;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!btn_s_q[i]) begin
                        state_d[i] = ST_ARM_LO;
                        cnt_d[i]   = '0;
                    end
                end
                ST_ARM_LO: begin
                    if (btn_s_q[i]) begin
                        state_d[i] = ST_HIGH;
                        cnt_d[i]   = '0;
                    end else if (cnt_q[i] == CNT_TC) begin
                        state_d[i] = ST_LOW;
                    end else begin
                        cnt_d[i] = cnt_q[i] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[i] = ST_LOW;
                    cnt_d[i]   = '0;
                end
            endcase
            // Level and release pulse are registered off the next state so
            // they change on the same edge as the committing transition.
            lvl_d[i] = (state_d[i] == ST_HIGH) || (state_d[i] == ST_ARM_LO);
            rel_d[i] = (state_q[i] == ST_ARM_LO) && (state_d[i] == ST_LOW);
        end
    end

    // The guard only saturates after the write channel has sat in LOW for
    // four cycles, so din stays frozen from the first write bounce until the
    // FIFO has had time to capture the word after the release.
    always_comb begin
        guard_d = '0;
        if (state_q[0] == ST_LOW) begin
            guard_d = (guard_q == GUARD_MAX) ? guard_q : guard_q + 3'd1;
        end
        din_d = (guard_q == GUARD_MAX) ? sw_s_q : din_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta_q <= '0;
            btn_s_q    <= '0;
            sw_meta_q  <= '0;
            sw_s_q     <= '0;
            state_q    <= {ST_LOW, ST_LOW};
            cnt_q      <= '0;
            lvl_q      <= '0;
            rel_q      <= '0;
            guard_q    <= '0;
            din_q      <= '0;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_s_q    <= btn_s_d;
            sw_meta_q  <= sw_meta_d;
            sw_s_q     <= sw_s_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            rel_q      <= rel_d;
            guard_q    <= guard_d;
            din_q      <= din_d;
        end
    end

    assign bus.write  = lvl_q[0];
    assign bus.read   = lvl_q[1];
    assign bus.wr_rel = rel_q[0];
    assign bus.rd_rel = rel_q[1];
    assign bus.din    = din_q;

endmodule

// File: tb/tb_fifo_input_conditioner.sv
module tb_fifo_input_conditioner;

    localparam int DBIT  = 3;
    localparam int NVEC  = 86;

    typedef struct {
        logic            rst;
        logic            bw;
        logic            br;
        logic [DBIT-1:0] sw;
        logic            ew;
        logic            er;
        logic            ewr;
        logic            err;
        logic [DBIT-1:0] edin;
    } vec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    vec_t tbl [NVEC];

    fifo_input_conditioner_if #(.dbit(DBIT)) bus ();

    fifo_input_conditioner #(
        .dbit      (DBIT),
        .DB_CYCLES (4),
        .CNT_W     (20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, want finished");
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] pack(input logic w, input logic r, input logic wr,
                                         input logic rr, input logic [DBIT-1:0] d);
        return {9'b0, w, r, wr, rr, d};
    endfunction

    initial begin
        n_vec = 0;
        n_err = 0;

        // Timeline, one record per clock edge; expected values are the
        // outputs just after that edge (press/release latency = 6 edges).
        //   0..2   reset with all inputs high
        //   3..14  both buttons held -> write/read rise together at 9
        //   15..29 both released     -> fall + both rel pulses at 21,
        //                               din tracks sw (7) from 26
        //   30..   sw=5 -> din=5 at 32; write press 34..53, sw=2 at 44,
        //          release at 54 -> write falls 60, din becomes 2 at 65
        //   70..72 3-cycle write glitch (ignored)
        //   70..75 read bounce 1,0,1,1,0,1 then held -> read rises at 81
        for (int i = 0; i < NVEC; i++) begin
            tbl[i].rst  = (i < 3);
            tbl[i].bw   = (i < 15) || (i >= 34 && i < 54) || (i >= 70 && i < 73);
            tbl[i].br   = (i < 15) || (i == 70) || (i == 72) || (i == 73) || (i >= 75);
            tbl[i].sw   = (i < 30) ? 3'b111 : (i < 44) ? 3'b101 : 3'b010;
            tbl[i].ew   = (i >= 9 && i < 21) || (i >= 40 && i < 60);
            tbl[i].er   = (i >= 9 && i < 21) || (i >= 81);
            tbl[i].ewr  = (i == 21) || (i == 60);
            tbl[i].err  = (i == 21);
            tbl[i].edin = (i < 26) ? 3'b000 : (i < 32) ? 3'b111 : (i < 65) ? 3'b101 : 3'b010;
        end

        for (int i = 0; i < NVEC; i++) begin
            rst        = tbl[i].rst;
            bus.btn_wr = tbl[i].bw;
            bus.btn_rd = tbl[i].br;
            bus.sw     = tbl[i].sw;
            step();
            check($sformatf("vec%0d {wr,rd,wr_rel,rd_rel,din}", i),
                  pack(bus.write, bus.read, bus.wr_rel, bus.rd_rel, bus.din),
                  pack(tbl[i].ew, tbl[i].er, tbl[i].ewr, tbl[i].err, tbl[i].edin));
        end

        // Reset while the write channel is mid-release (ARM_LO).
        rst        = 1'b1;
        bus.btn_wr = 1'b0;
        bus.btn_rd = 1'b0;
        bus.sw     = 3'b000;
        step();
        step();
        check("midrst_pre_reset_outputs",
              pack(bus.write, bus.read, bus.wr_rel, bus.rd_rel, bus.din),
              pack(1'b0, 1'b0, 1'b0, 1'b0, 3'b000));
        rst        = 1'b0;
        bus.btn_wr = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("midrst_press_edge6_write", {15'b0, bus.write}, 16'd0);
        step();
        check("midrst_press_edge7_write", {15'b0, bus.write}, 16'd1);
        bus.btn_wr = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("midrst_arm_lo_write_held", {15'b0, bus.write}, 16'd1);
        rst = 1'b1;
        step();
        check("midrst_reset_write_wr_rel", {14'b0, bus.write, bus.wr_rel}, 16'd0);
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            step();
            check($sformatf("midrst_after%0d_write_wr_rel", k),
                  {14'b0, bus.write, bus.wr_rel}, 16'd0);
        end
        // A fresh press must again take exactly the full latency from LOW.
        bus.btn_wr = 1'b1;
        for (int k = 0; k < 6; k++) step();
        check("midrst_repress_edge6_write", {15'b0, bus.write}, 16'd0);
        step();
        check("midrst_repress_edge7_write", {15'b0, bus.write}, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_input_conditioner.md
# fifo_input_conditioner

Front-end stage that sits directly upstream of the board FIFO buffer: conditions the raw push-button and slide-switch inputs of the FPGA board into the clean `write`, `read` and `din` levels the FIFO consumes. Each button is synchronised and debounced by a per-channel state machine with a stable-sample counter. The switch data word is synchronised and frozen around every write press, so the FIFO captures a stable word on the write release edge.

## Interface
- `dbit`, 3, data width; must match the downstream FIFO.
- `DB_CYCLES`, 1000000, consecutive stable synchronised samples required to commit a level change (10 ms at 100 MHz); legal range 2..2**CNT_W.
- `CNT_W`, 20, debounce counter width.
- `clk` in 1: single clock for all logic.
- `rst` in 1: synchronous, active-high reset.
- `btn_wr` in 1: raw write push-button, asynchronous, bouncy.
- `btn_rd` in 1: raw read push-button, asynchronous, bouncy.
- `sw` in `dbit`: raw data switches, asynchronous.
- `write` out 1: debounced write level, drives FIFO `write`.
- `read` out 1: debounced read level, drives FIFO `read`.
- `din` out `dbit`: held data word, drives FIFO `din`.
- `wr_rel` out 1: one-cycle pulse on committed write-button release.
- `rd_rel` out 1: one-cycle pulse on committed read-button release.

## Operation
- **Synchroniser:** each of `btn_wr`, `btn_rd` and every `sw` bit passes through two flops, giving the synchronised value `s`. No logic reads the raw inputs directly.
- **Channel FSM:** one instance per button, with states LOW, ARM_HI, HIGH, ARM_LO.
  - LOW: if `s`=1, go to ARM_HI and set cnt=0.
  - ARM_HI: if `s`=0, return to LOW (bounce). Otherwise, if cnt==DB_CYCLES-1, go to HIGH; else cnt+1.
  - HIGH: if `s`=0, go to ARM_LO and set cnt=0.
  - ARM_LO: if `s`=1, return to HIGH. Otherwise, if cnt==DB_CYCLES-1, go to LOW; else cnt+1.
  - The output level is registered: it is 1 exactly while the state is HIGH or ARM_LO.
  - `*_rel` is 1 for exactly the one cycle after the ARM_LO->LOW transition, coincident with the output's falling edge.
- **Counter:** width CNT_W, never wraps. It is cleared on every entry to ARM_HI or ARM_LO and on every bounce.
- **Data hold:**
  - A 3-bit guard counter increments while the write FSM is in LOW, saturating at 4. It is cleared in any other write-FSM state.
  - `din` loads the synchronised `sw` on every cycle in which the guard is 4. Otherwise `din` holds.
  - Result: `din` is frozen from the first write bounce until 4 cycles after the write release, which covers the FIFO's delayed capture of its data input.
- **Independence:** the two channels are fully independent. Simultaneous presses or releases each commit on their own schedule, and both `*_rel` pulses may assert in the same cycle.
- **Reset:** clears all synchroniser flops, puts both FSMs in LOW, and zeroes the counters, guard, `write`, `read`, `din`, `wr_rel` and `rd_rel`.
  - Reset asserted mid-operation, in any state including a pending ARM_HI or ARM_LO, aborts it. No `*_rel` pulse is generated for an aborted press.

## Timing
- Reset values: `write`=0, `read`=0, `din`=0, `wr_rel`=0, `rd_rel`=0.
- Press latency: button stable high sampled at edge t gives `write`/`read` = 1 after edge t+2+DB_CYCLES (2 sync cycles + DB_CYCLES).
- Release latency: identical, DB_CYCLES+2 edges. `*_rel` is high for the single cycle after that edge.
- A glitch shorter than DB_CYCLES synchronised cycles produces no output change and no `*_rel` pulse.
- After reset release, `din` first tracks `sw` 4 cycles after the guard starts counting. With switch synchronisation, `din` reflects `sw` within 7 cycles.
- Minimum press-to-press spacing: 2*(DB_CYCLES+2) cycles. Faster toggling is treated as bounce.

## Test plan
Run with `DB_CYCLES`=4, `dbit`=3.
- **Reset:** hold `rst` 3 cycles with all inputs at 1 -> all outputs 0 during and the cycle after reset; `write` rises exactly 6 edges after `btn_wr` is first sampled high post-reset.
- **Clean press:** `btn_wr` 0->1 held 20 cycles, then 1->0 -> `write` high 6 edges after the rise, low 6 edges after the fall; `wr_rel` is a single 1-cycle pulse coincident with `write` falling.
- **Bounce:** `btn_rd` toggles 1,0,1,1,0,1 (one value per cycle), then holds 1 -> `read` stays 0 through the toggling and rises 6 edges after the final stable 1; no `rd_rel` pulse.
- **Data freeze:** `sw`=3'b101, press write, change `sw` to 3'b010 while `write`=1, then release -> `din` stays 3'b101 until 4 cycles after `write` falls, then becomes 3'b010.
- **Simultaneous:** press and release both buttons in the same cycles -> `write` and `read` rise together; `wr_rel` and `rd_rel` pulse in the same cycle.
- **Reset mid-operation:** assert `rst` while the write FSM is in ARM_LO -> `write`=0 next cycle, `wr_rel` never pulses, FSM back in LOW.
